// File: rtl/param_memory_module.sv
// param_memory_module: single-port write-first RAM with req/ready handshake and a sequential clear engine
// Ports: clk, rst (sync, active-high), clr (start clear from IDLE), req/we/addr/in_data (access),
//        ready/busy (IDLE vs CLEAR), out_valid (one-cycle pulse per accepted access), out_data (read or write data)
module param_memory_module #(
  parameter int DATA_W = 15,
  parameter int ADDR_W = 3,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              ready,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  // The clear engine and the access path share the single array port.
  always_comb begin
    state_d = state_q;
    clr_ptr_d = clr_ptr_q;
    out_data_d = out_data_q;
    out_valid_d = 1'b0;
    mem_we = 1'b0;
    mem_addr = addr;
    mem_wdata = in_data;
    if (state_q == CLEAR) begin
      mem_we = 1'b1;
      mem_addr = clr_ptr_q;
      mem_wdata = INIT_VAL;
      clr_ptr_d = clr_ptr_q + 1'b1;
      state_d = &clr_ptr_q ? IDLE : CLEAR;
    end else if (clr) begin
      state_d = CLEAR;
      clr_ptr_d = '0;
      out_data_d = '0;
    end else if (req) begin
      out_valid_d = 1'b1;
      mem_we = we;
      out_data_d = we ? in_data : mem[addr];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_ptr_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_ptr_q <= clr_ptr_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign ready = state_q == IDLE;
  assign busy = ~ready;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
endmodule

// File: tb/tb_param_memory_module.sv
// tb_param_memory_module: randomized and directed checks of param_memory_module against a behavioural model
module tb_param_memory_module;
  logic clk;
  int checks = 0;
  int errors = 0;
  logic a_rst, a_clr, a_req, a_we;
  logic [2:0] a_addr;
  logic [14:0] a_in;
  logic a_ready, a_busy, a_valid;
  logic [14:0] a_out;
  logic b_rst, b_clr, b_req, b_we;
  logic [4:0] b_addr;
  logic [31:0] b_in;
  logic b_ready, b_busy, b_valid;
  logic [31:0] b_out;
  param_memory_module dut_a (
    .clk(clk), .rst(a_rst), .clr(a_clr), .req(a_req), .we(a_we), .addr(a_addr),
    .in_data(a_in), .ready(a_ready), .busy(a_busy), .out_valid(a_valid), .out_data(a_out)
  );
  param_memory_module #(.DATA_W(32), .ADDR_W(5), .INIT_VAL(32'hDEADBEEF)) dut_b (
    .clk(clk), .rst(b_rst), .clr(b_clr), .req(b_req), .we(b_we), .addr(b_addr),
    .in_data(b_in), .ready(b_ready), .busy(b_busy), .out_valid(b_valid), .out_data(b_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  int ref_mem [8];
  int clear_left = 8;
  int exp_data = 0;
  bit exp_valid = 0;
  task automatic step_a(input bit r, input bit c, input bit q, input bit w, input int ad, input int d);
    a_rst = r;
    a_clr = c;
    a_req = q;
    a_we = w;
    a_addr = 3'(ad);
    a_in = 15'(d);
    @(posedge clk);
    #1;
    exp_valid = 0;
    if (r) begin
      clear_left = 8;
      exp_data = 0;
    end else if (clear_left > 0) begin
      ref_mem[8 - clear_left] = 0;
      clear_left--;
    end else if (c) begin
      clear_left = 8;
      exp_data = 0;
    end else if (q) begin
      exp_valid = 1;
      if (w) ref_mem[ad] = d;
      exp_data = ref_mem[ad];
    end
    check("a_ready", 32'(a_ready), 32'(clear_left == 0));
    check("a_busy", 32'(a_busy), 32'(clear_left != 0));
    check("a_valid", 32'(a_valid), 32'(exp_valid));
    check("a_data", 32'(a_out), exp_data);
  endtask
  task automatic step_b(input bit r, input bit q, input bit w, input int ad, input logic [31:0] d);
    b_rst = r;
    b_clr = 1'b0;
    b_req = q;
    b_we = w;
    b_addr = 5'(ad);
    b_in = d;
    @(posedge clk);
    #1;
  endtask
  int wvals [8] = '{2747, 7503, 29928, 4993, 27060, 17640, 32641, 2562};
  initial begin
    int n;
    step_b(1, 0, 0, 0, 0);
    step_b(1, 0, 0, 0, 0);
    check("b_rst_busy", 32'(b_busy), 1);
    n = 0;
    while (!b_ready && n < 100) begin
      step_b(0, 0, 0, 0, 0);
      n++;
    end
    check("b_clear_len", n, 32);
    step_b(0, 1, 0, 31, 0);
    check("b_rd31_valid", 32'(b_valid), 1);
    check("b_rd31_data", b_out, 32'hDEADBEEF);
    step_b(0, 1, 1, 17, 32'hA5A5_5A5A);
    check("b_wr17", b_out, 32'hA5A5_5A5A);
    step_b(0, 1, 0, 17, 0);
    check("b_rd17", b_out, 32'hA5A5_5A5A);
    for (int i = 0; i < 8; i++) begin
      step_b(0, 1, 0, int'($urandom_range(16)), 0);
      check("b_rd_init", b_out, 32'hDEADBEEF);
    end
    step_b(0, 0, 0, 0, 0);
  end
  initial begin
    step_a(1, 0, 0, 0, 0, 0);
    step_a(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step_a(0, 0, int'($urandom_range(1)), 1, i, 5);
    for (int i = 0; i < 8; i++) step_a(0, 0, 1, 1, i, wvals[i]);
    for (int i = 0; i < 8; i++) begin
      step_a(0, 0, 1, 0, i, 0);
      check("a_readback", 32'(a_out), wvals[i]);
    end
    step_a(0, 0, 1, 1, 5, 'h1234);
    step_a(0, 0, 1, 0, 5, 0);
    check("a_b2b", 32'(a_out), 'h1234);
    step_a(0, 1, 1, 1, 2, 'h7FFF);
    for (int i = 0; i < 8; i++) step_a(0, 0, 1, 1, 2, 'h7FFF);
    for (int i = 0; i < 8; i++) begin
      step_a(0, 0, 1, 0, i, 0);
      check("a_cleared", 32'(a_out), 0);
    end
    step_a(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step_a(0, 0, 1, 1, i, 99);
    step_a(1, 0, 1, 1, 4, 99);
    for (int i = 0; i < 8; i++) step_a(0, 0, 1, int'($urandom_range(1)), i, 77);
    for (int i = 0; i < 2000; i++) begin
      int p;
      p = int'($urandom_range(99));
      step_a(p < 2, p >= 2 && p < 6, $urandom_range(99) < 65, 1'($urandom),
             int'($urandom_range(7)), int'($urandom_range(32767)));
    end
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
